// File: rtl/mem_pkg.sv
// Shared types and constants for the cache-side main memory.
// Also provides the word-index power-up fill pattern.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BLOCKS          = 64;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_W        = 4;
  localparam int IDX_W           = 6;
  localparam int LINE_W          = 128;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // word k of memory holds k; word k of block b is k = 4*b + w
  function automatic logic [LINE_W-1:0] init_block(
    input logic [IDX_W-1:0] blk
  );
    logic [LINE_W-1:0] b;
    b = '0;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      b[w*32 +: 32] = {24'd0, blk, 2'(w)};
    end
    return b;
  endfunction

endpackage

// File: rtl/mem_block_array.sv
// 64 x 128-bit block store, one write port, one registered read port.
// Cells hold data XOR the init fill, so zeroed cells read as the fill.
module mem_block_array
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem_q [BLOCKS];
  logic [LINE_W-1:0] rdata_d;
  logic [LINE_W-1:0] rdata_q;

  // array write; contents survive reset
  always_ff @(posedge clock) begin
    if (we) mem_q[idx] <= wdata ^ init_block(idx);
  end

  // read data only changes on a read access
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[idx] ^ init_block(idx);
  end

  // read data register
  always_ff @(posedge clock) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency block memory behind a req/done handshake.
// Latches one request, counts down, accesses, pulses done.
module main_memory_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_cache,
  input  logic               read_cache,
  input  logic [ADDR_W-1:0]  addr_cache,
  input  logic [BLOCK_W-1:0] WriteData_cache,
  output logic [BLOCK_W-1:0] ReadData_mem,
  output logic               done_mem,
  output logic               busy_mem
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam int BLK_W = ADDR_W - OFFSET_W;

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [BLK_W-1:0]   blk_d, blk_q;
  logic               rw_d, rw_q;
  logic [BLOCK_W-1:0] wdata_d, wdata_q;
  logic               we, re;
  logic               unused_offset;

  assign unused_offset = ^addr_cache[OFFSET_W-1:0];

  // next state, request latching and access strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_cache) begin
          blk_d   = addr_cache[ADDR_W-1:OFFSET_W];
          rw_d    = read_cache;
          wdata_d = WriteData_cache;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          we      = (rw_q == RW_WRITE) && !reset;
          re      = (rw_q == RW_READ);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counter and latched request
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  assign done_mem = (state_q == ST_DONE);
  assign busy_mem = (state_q != ST_IDLE);

  mem_block_array u_array (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .re    (re),
    .idx   (blk_q),
    .wdata (wdata_q),
    .rdata (ReadData_mem)
  );

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench: LATENCY=4 instance with random traffic,
// plus a LATENCY=1 instance with a continuously held request.
module tb_main_memory_ctrl;

  localparam int L1 = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req, rd_n;
  logic [9:0]   addr;
  logic [127:0] wd;
  logic [127:0] rdata;
  logic         done, busy;

  logic         req2;
  logic [127:0] rdata2;
  logic         done2, busy2;
  logic [127:0] wd2 = '0;
  logic [9:0]   addr2 = 10'h3F0;
  logic         rd2 = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_memory_ctrl #(.ADDR_W(10), .BLOCK_W(128), .LATENCY(L1)) dut (
    .clock(clk), .reset(reset), .req_cache(req), .read_cache(rd_n),
    .addr_cache(addr), .WriteData_cache(wd), .ReadData_mem(rdata),
    .done_mem(done), .busy_mem(busy)
  );

  main_memory_ctrl #(.ADDR_W(10), .BLOCK_W(128), .LATENCY(1)) dut1 (
    .clock(clk), .reset(reset), .req_cache(req2), .read_cache(rd2),
    .addr_cache(addr2), .WriteData_cache(wd2), .ReadData_mem(rdata2),
    .done_mem(done2), .busy_mem(busy2)
  );

  // reference model: flat word memory, word k = k at power-up
  logic [31:0]  mw [256];
  logic [127:0] last_read;

  typedef struct {
    bit           rd;
    logic [127:0] data;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] model_blk(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = mw[b*4 + w];
    return r;
  endfunction

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.rd ? "read_data" : "write_hold", rdata, e.data);
        chk("done_latency", 128'(cyc), 128'(e.cyc + L1));
      end
    end
  end

  // from a negedge with the DUT idle: issue, then scramble inputs while busy
  task automatic do_txn(input bit is_wr, input logic [9:0] a,
                        input logic [127:0] d);
    int b;
    exp_t e;
    req = 1'b1; rd_n = is_wr; addr = a; wd = d;
    @(posedge clk); #1;
    b = int'(a[9:4]);
    if (is_wr) begin
      for (int w = 0; w < 4; w++) mw[b*4 + w] = d[w*32 +: 32];
      e.data = last_read;
    end else begin
      last_read = model_blk(b);
      e.data = last_read;
    end
    e.rd = !is_wr;
    e.cyc = cyc;
    sb.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin
        req = 1'b0;
        return;
      end
      req  = 1'($urandom);
      rd_n = 1'($urandom);
      addr = 10'($urandom);
      wd   = {$urandom, $urandom, $urandom, $urandom};
    end
    chk("busy_timeout", 128'(busy), 128'd0);
    $fatal(1, "FAIL busy_timeout: DUT stuck busy");
  endtask

  // write accepted, reset lands two edges later: write must not commit
  task automatic abort_write(input logic [9:0] a, input logic [127:0] d);
    req = 1'b1; rd_n = 1'b1; addr = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_read = '0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_rdata", rdata, 128'd0);
  endtask

  initial begin
    bit is_wr;
    logic [9:0] a, prev_a;
    for (int k = 0; k < 256; k++) mw[k] = 32'(k);
    last_read = '0;
    reset = 1'b1; req = 1'b0; rd_n = 1'b0; addr = '0; wd = '0;
    req2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_rdata", rdata, 128'd0);
    chk("reset_done_l1", 128'(done2), 128'd0);
    chk("reset_rdata_l1", rdata2, 128'd0);

    do_txn(1'b0, 10'h014, '0);
    chk("blk1_const", last_read,
        128'h00000007_00000006_00000005_00000004);
    do_txn(1'b1, 10'h03C, 128'hDEADBEEF_00000000_00000000_CAFEF00D);
    do_txn(1'b0, 10'h030, '0);
    chk("blk3_const", last_read,
        128'hDEADBEEF_00000000_00000000_CAFEF00D);

    abort_write(10'h05C, 128'h11111111_22222222_33333333_44444444);
    do_txn(1'b0, 10'h053, '0);
    chk("blk5_const", last_read,
        128'h00000017_00000016_00000015_00000014);

    prev_a = 10'h030;
    for (int n = 0; n < 150; n++) begin
      is_wr = 1'($urandom);
      a = 10'($urandom);
      if ($urandom_range(3) == 0) a = {prev_a[9:4], 4'($urandom)};
      do_txn(is_wr, a, {$urandom, $urandom, $urandom, $urandom});
      prev_a = a;
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);

    req2 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("l1_done_pattern", 128'(done2), 128'((i % 3) == 1));
      if (done2)
        chk("l1_blk63", rdata2,
            128'h000000FF_000000FE_000000FD_000000FC);
    end
    req2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("l1_idle", 128'(busy2), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
